// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter sharing one multiplier among R requesters.
// Latches winner operands, runs start/finished handshake, returns product.
module multiplier_arbiter #(
  parameter int N = 4,
  parameter int R = 4
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic [R-1:0]   i_request,
  input  logic [R*N-1:0] i_multiplicands,
  input  logic [R*N-1:0] i_multipliers,
  output logic [R-1:0]   o_grant,
  output logic [R-1:0]   o_done,
  output logic [2*N-1:0] o_product,
  output logic           o_busy,
  output logic           o_mul_start,
  output logic [N-1:0]   o_mul_multiplicand,
  output logic [N-1:0]   o_mul_multiplier,
  input  logic           i_mul_finished,
  input  logic [2*N-1:0] i_mul_product
);

  localparam int PW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  gidx_q, gidx_d;
  logic [R-1:0]   grant_q, grant_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           fin_q;
  logic           rise;
  logic           found;
  logic [PW-1:0]  win;

  // a level finished left high by the previous op must not count
  assign rise = i_mul_finished & ~fin_q;

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < R; i++) begin
      if (!found && i_request[(int'(ptr_q) + i) % R]) begin
        found = 1'b1;
        win   = PW'((int'(ptr_q) + i) % R);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    prod_d  = prod_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gidx_d       = win;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          a_d          = i_multiplicands[int'(win)*N +: N];
          b_d          = i_multipliers[int'(win)*N +: N];
          state_d      = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (rise) begin
          prod_d  = i_mul_product;
          state_d = DONE;
        end
      end
      DONE: begin
        grant_d = '0;
        ptr_d   = (gidx_q == PW'(R - 1)) ? '0 : gidx_q + PW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      prod_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      prod_q  <= prod_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fin_q   <= i_mul_finished;
    end
  end

  assign o_grant            = grant_q;
  assign o_done             = (state_q == DONE) ? grant_q : '0;
  assign o_product          = prod_q;
  assign o_busy             = (state_q != IDLE);
  assign o_mul_start        = (state_q == START);
  assign o_mul_multiplicand = a_q;
  assign o_mul_multiplier   = b_q;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Self-checking bench for multiplier_arbiter.
// Transaction-level model plus directed scenarios with literal checks.
module tb_multiplier_arbiter;

  localparam int N   = 4;
  localparam int R   = 4;
  localparam int LAT = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [R-1:0]   req = '0;
  logic [R*N-1:0] mc = '0;
  logic [R*N-1:0] mp = '0;
  logic [R-1:0]   grant, done;
  logic [2*N-1:0] product;
  logic           busy, mstart;
  logic [N-1:0]   ma, mb;
  logic           mfin;
  logic [2*N-1:0] mprod;
  logic           level_mode = 1'b0;
  logic           auto_drop = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int starts  = 0;
  int dl_idx[$];
  int dl_prod[$];

  always #5 clk = ~clk;

  multiplier_arbiter #(.N(N), .R(R)) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .i_request(req),
    .i_multiplicands(mc),
    .i_multipliers(mp),
    .o_grant(grant),
    .o_done(done),
    .o_product(product),
    .o_busy(busy),
    .o_mul_start(mstart),
    .o_mul_multiplicand(ma),
    .o_mul_multiplier(mb),
    .i_mul_finished(mfin),
    .i_mul_product(mprod)
  );

  // multiplier stand-in: finished LAT edges after start
  logic run;
  int   k;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      k     <= 0;
      mfin  <= 1'b0;
      mprod <= '0;
    end else begin
      if (!level_mode) mfin <= 1'b0;
      if (mstart) begin
        run <= 1'b1;
        k   <= 1;
      end else if (run) begin
        k <= k + 1;
        if (level_mode && k == 1) mfin <= 1'b0;
        if (k == LAT) begin
          mfin  <= 1'b1;
          mprod <= {{N{1'b0}}, ma} * {{N{1'b0}}, mb};
          run   <= 1'b0;
        end
      end
    end
  end

  typedef struct {
    int             owner;
    int             cyc;
    int             tdone;
    int             p;
    logic           prevfin;
    logic [2*N-1:0] prod;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
  } model_t;

  function automatic model_t m_reset();
    model_t r;
    r.owner   = -1;
    r.cyc     = 0;
    r.tdone   = -1;
    r.p       = 0;
    r.prevfin = 1'b0;
    r.prod    = '0;
    r.a       = '0;
    r.b       = '0;
    return r;
  endfunction

  // cyc counts cycles since the arbitration edge; tdone is the done cycle
  function automatic model_t m_step(model_t s, logic [R-1:0] rq,
                                    logic [R*N-1:0] xa, logic [R*N-1:0] xb,
                                    logic fin, logic [2*N-1:0] pr);
    model_t n = s;
    if (s.owner < 0) begin
      for (int i = 0; i < R; i++)
        if (n.owner < 0 && rq[(s.p + i) % R]) n.owner = (s.p + i) % R;
      if (n.owner >= 0) begin
        n.cyc   = 1;
        n.tdone = -1;
        n.a     = xa[n.owner*N +: N];
        n.b     = xb[n.owner*N +: N];
      end
    end else if (s.cyc == s.tdone) begin
      n.p     = (s.owner + 1) % R;
      n.owner = -1;
    end else begin
      if (s.cyc >= 2 && s.tdone < 0 && fin && !s.prevfin) begin
        n.tdone = s.cyc + 1;
        n.prod  = pr;
      end
      n.cyc = s.cyc + 1;
    end
    n.prevfin = fin;
    return n;
  endfunction

  model_t ms;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ms <= m_reset();
    else ms <= m_step(ms, req, mc, mp, mfin, mprod);
  end

  logic [R-1:0] eg, ed;
  always @(negedge clk) begin
    eg = '0;
    if (ms.owner >= 0) eg[ms.owner] = 1'b1;
    ed = (ms.owner >= 0 && ms.cyc == ms.tdone) ? eg : '0;
    n_tests++;
    if (grant !== eg || done !== ed || product !== ms.prod ||
        busy !== (ms.owner >= 0) ||
        mstart !== (ms.owner >= 0 && ms.cyc == 1) ||
        ma !== ms.a || mb !== ms.b) begin
      n_fail++;
      $display("FAIL cycle t=%0t grant=%b/%b done=%b/%b prod=%0d/%0d busy=%b start=%b a=%0d/%0d b=%0d/%0d",
               $time, grant, eg, done, ed, product, ms.prod, busy, mstart,
               ma, ms.a, mb, ms.b);
    end
    if (done != '0) begin
      dl_idx.push_back($clog2(int'(done)));
      dl_prod.push_back(int'(product));
    end
    if (mstart) starts++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    if (auto_drop) req = req & ~done;
  endtask

  task automatic wait_log(input int n, input int bound);
    int c = 0;
    while (dl_idx.size() < n && c < bound) begin
      step();
      c++;
    end
    if (dl_idx.size() < n) chk("timeout", dl_idx.size(), n);
  endtask

  task automatic set_op(input int r, input int a, input int b);
    mc[r*N +: N] = N'(a);
    mp[r*N +: N] = N'(b);
  endtask

  task automatic chk_log(input string nm, input int i, input int idx, input int pr);
    if (i < dl_idx.size()) begin
      chk({nm, "_idx"}, dl_idx[i], idx);
      chk({nm, "_prod"}, dl_prod[i], pr);
    end else chk({nm, "_missing"}, dl_idx.size(), i + 1);
  endtask

  int s0, sz;
  initial begin
    #1 rst_n = 1'b0;
    step();
    step();
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_prod", int'(product), 0);
    chk("rst_start", int'(mstart), 0);
    rst_n = 1'b1;
    step();

    // single request
    auto_drop = 1'b1;
    set_op(2, 7, 9);
    req = 4'b0100;
    s0 = starts;
    wait_log(1, 30);
    chk_log("single", 0, 2, 63);
    repeat (3) step();
    chk("single_starts", starts - s0, 1);

    // simultaneous requests from p=0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    set_op(0, 1, 2);
    set_op(1, 3, 4);
    set_op(2, 15, 15);
    set_op(3, 0, 9);
    req = 4'b1111;
    wait_log(5, 80);
    chk_log("sim0", 1, 0, 2);
    chk_log("sim1", 2, 1, 12);
    chk_log("sim2", 3, 2, 225);
    chk_log("sim3", 4, 3, 0);
    repeat (5) step();
    chk("sim_count", dl_idx.size(), 5);

    // fairness, 0 and 3 held continuously
    auto_drop = 1'b0;
    set_op(0, 2, 3);
    set_op(3, 4, 5);
    req = 4'b1001;
    wait_log(11, 120);
    req = '0;
    for (int i = 0; i < 6; i++)
      chk_log("fair", 5 + i, (i % 2 == 0) ? 0 : 3, (i % 2 == 0) ? 6 : 20);
    repeat (5) step();
    chk("fair_count", dl_idx.size(), 11);

    // dropped request with operands cleared during WAIT
    set_op(1, 5, 6);
    req = 4'b0010;
    repeat (3) step();
    req = '0;
    set_op(1, 0, 0);
    wait_log(12, 30);
    chk_log("drop", 11, 1, 30);
    repeat (10) step();
    chk("drop_count", dl_idx.size(), 12);

    // level finished held high between operations
    level_mode = 1'b1;
    auto_drop = 1'b1;
    s0 = starts;
    set_op(2, 3, 5);
    req = 4'b0100;
    wait_log(13, 30);
    set_op(2, 11, 13);
    req = 4'b0100;
    wait_log(14, 30);
    chk_log("stale0", 12, 2, 15);
    chk_log("stale1", 13, 2, 143);
    repeat (6) step();
    chk("stale_starts", starts - s0, 2);
    chk("stale_count", dl_idx.size(), 14);
    level_mode = 1'b0;
    step();

    // reset during WAIT
    set_op(3, 2, 2);
    req = 4'b1000;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_grant", int'(grant), 0);
    chk("mid_done", int'(done), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_prod", int'(product), 0);
    chk("mid_ops", int'({ma, mb, mstart}), 0);
    sz = dl_idx.size();
    req = '0;
    step();
    step();
    rst_n = 1'b1;
    repeat (8) step();
    chk("mid_nodone", dl_idx.size(), sz);
    set_op(1, 6, 7);
    req = 4'b0010;
    wait_log(sz + 1, 30);
    chk_log("post_rst", sz, 1, 42);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
